// File: rtl/interp_ser_ctrl.sv
// interp_ser_ctrl
// Frame controller in front of a 4:1 polyphase serializer. A single pending
// frame register P feeds the serializer's parallel inputs. A two-state FSM
// (HOLD/SHIFT) drives the serializer load. The serializer captures P on the
// HOLD->SHIFT edge and then shifts out four samples, din3 first. Status
// outputs are registered so they line up with the serializer's registered dout.

module interp_ser_ctrl #(
    parameter int DW  = 10,
    parameter int UCW = 8
) (
    input  logic           CLK,
    input  logic           Reset,
    input  logic           run,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_p0,
    input  logic [DW-1:0]  in_p1,
    input  logic [DW-1:0]  in_p2,
    input  logic [DW-1:0]  in_p3,
    output logic           load,
    output logic [DW-1:0]  din0,
    output logic [DW-1:0]  din1,
    output logic [DW-1:0]  din2,
    output logic [DW-1:0]  din3,
    output logic           out_valid,
    output logic [1:0]     out_phase,
    output logic           frame_done,
    output logic [UCW-1:0] underrun_cnt
);

    typedef enum logic {
        ST_HOLD  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Saturating increment for the underrun counter: sticks at all-ones.
    function automatic logic [UCW-1:0] sat_inc(input logic [UCW-1:0] v);
        if (v == {UCW{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(UCW-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_phase;
    logic           r_p_full;
    logic [DW-1:0]  r_p0;
    logic [DW-1:0]  r_p1;
    logic [DW-1:0]  r_p2;
    logic [DW-1:0]  r_p3;
    logic           r_out_valid;
    logic [1:0]     r_out_phase;
    logic           r_frame_done;
    logic [UCW-1:0] r_underrun_cnt;

    logic           w_consume;
    logic           w_ready;
    logic           w_accept;
    logic           w_last;
    logic           w_underrun;

    // A pending frame moves into the serializer when it is waiting in HOLD and
    // running. That same edge frees P, so a new frame may enter alongside it.
    assign w_consume  = (r_state == ST_HOLD) & r_p_full & run;
    assign w_ready    = ~r_p_full | w_consume;
    assign w_accept   = in_valid & w_ready;
    assign w_last     = (r_state == ST_SHIFT) & (r_phase == 2'd3);
    assign w_underrun = w_last & run & ~r_p_full & ~w_accept;

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: four shift cycles per frame keep the serializer aligned.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HOLD: begin
                if (r_p_full & run) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_SHIFT: begin
                if (r_phase == 2'd3) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    // State-decoded outputs: load freezes/captures the serializer in HOLD.
    always_comb begin
        load     = 1'b1;
        in_ready = w_ready;
        case (r_state)
            ST_HOLD:  load = 1'b1;
            ST_SHIFT: load = 1'b0;
            default:  load = 1'b1;
        endcase
    end

    // Phase counter: held at 0 in HOLD, counts 0..3 through the shift cycles.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_phase <= 2'd0;
        end else if (r_state == ST_SHIFT) begin
            r_phase <= r_phase + 2'd1;
        end else begin
            r_phase <= 2'd0;
        end
    end

    // Pending-frame register P; the serializer ignores it while shifting.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_p0 <= {DW{1'b0}};
            r_p1 <= {DW{1'b0}};
            r_p2 <= {DW{1'b0}};
            r_p3 <= {DW{1'b0}};
        end else if (w_accept) begin
            r_p0 <= in_p0;
            r_p1 <= in_p1;
            r_p2 <= in_p2;
            r_p3 <= in_p3;
        end else begin
            r_p0 <= r_p0;
            r_p1 <= r_p1;
            r_p2 <= r_p2;
            r_p3 <= r_p3;
        end
    end

    // Pending flag: a same-edge accept wins over the consume.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_p_full <= 1'b0;
        end else if (w_accept) begin
            r_p_full <= 1'b1;
        end else if (w_consume) begin
            r_p_full <= 1'b0;
        end else begin
            r_p_full <= r_p_full;
        end
    end

    // Status registers: delayed one cycle to match the serializer's dout.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_out_valid  <= 1'b0;
            r_out_phase  <= 2'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= (r_state == ST_SHIFT);
            r_out_phase  <= r_phase;
            r_frame_done <= w_last;
        end
    end

    // Underrun counter: counts frame gaps seen at the end of a shift while running.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_underrun_cnt <= {UCW{1'b0}};
        end else if (w_underrun) begin
            r_underrun_cnt <= sat_inc(r_underrun_cnt);
        end else begin
            r_underrun_cnt <= r_underrun_cnt;
        end
    end

    assign din0         = r_p0;
    assign din1         = r_p1;
    assign din2         = r_p2;
    assign din3         = r_p3;
    assign out_valid    = r_out_valid;
    assign out_phase    = r_out_phase;
    assign frame_done   = r_frame_done;
    assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_interp_ser_ctrl.sv
// Bench for interp_ser_ctrl: directed scenarios plus random traffic. The
// expected behaviour comes from a frame-queue reference model. A small
// behavioural serializer turns load/din into the sample stream.

module tb_interp_ser_ctrl;

    localparam int DW   = 10;
    localparam int UCW  = 2;
    localparam int UMAX = (1 << UCW) - 1;

    typedef logic [4*DW-1:0] frame_t;   // {p3,p2,p1,p0}

    logic           CLK = 1'b0;
    logic           Reset = 1'b1;
    logic           run = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DW-1:0]  in_p0 = '0, in_p1 = '0, in_p2 = '0, in_p3 = '0;
    logic           load;
    logic [DW-1:0]  din0, din1, din2, din3;
    logic           out_valid;
    logic [1:0]     out_phase;
    logic           frame_done;
    logic [UCW-1:0] underrun_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    interp_ser_ctrl #(.DW(DW), .UCW(UCW)) dut (
        .CLK(CLK), .Reset(Reset), .run(run), .in_valid(in_valid),
        .in_ready(in_ready), .in_p0(in_p0), .in_p1(in_p1), .in_p2(in_p2),
        .in_p3(in_p3), .load(load), .din0(din0), .din1(din1), .din2(din2),
        .din3(din3), .out_valid(out_valid), .out_phase(out_phase),
        .frame_done(frame_done), .underrun_cnt(underrun_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural 4:1 serializer: captures din while load=1, else emits din3..din0.
    frame_t        s_cap;
    logic [DW-1:0] s_dout;
    int            s_cnt;
    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            s_cap  <= '0;
            s_dout <= '0;
            s_cnt  <= 0;
        end else if (load) begin
            s_cap  <= {din3, din2, din1, din0};
            s_cnt  <= 0;
        end else begin
            s_dout <= s_cap[(3 - s_cnt) * DW +: DW];
            s_cnt  <= (s_cnt + 1) % 4;
        end
    end

    // Reference model: pending queue (at most one frame), shifts left in the
    // current frame, and the expected registered outputs.
    frame_t        m_pend[$];
    frame_t        m_cur = '0;
    frame_t        m_p = '0;
    int            m_left = 0;
    int            e_ucnt = 0;
    logic          e_ov = 1'b0;
    int            e_ph = 0;
    logic          e_fd = 1'b0;
    logic [DW-1:0] e_samp = '0;

    task automatic m_reset();
        m_pend.delete();
        m_cur = '0; m_p = '0; m_left = 0; e_ucnt = 0;
        e_ov = 1'b0; e_ph = 0; e_fd = 1'b0;
    endtask

    task automatic m_step();
        logic hold, ready, acc;
        frame_t f;
        f     = {in_p3, in_p2, in_p1, in_p0};
        hold  = (m_left == 0);
        ready = (m_pend.size() == 0) || (hold && run);
        acc   = in_valid && ready;
        e_ov  = !hold;
        e_ph  = hold ? 0 : 4 - m_left;
        e_fd  = (m_left == 1);
        if (!hold) e_samp = m_cur[(3 - e_ph) * DW +: DW];
        if (m_left == 1 && run && m_pend.size() == 0 && !acc && e_ucnt < UMAX) e_ucnt++;
        if (hold) begin
            if (m_pend.size() > 0 && run) begin
                m_cur  = m_pend.pop_front();
                m_left = 4;
            end
        end else begin
            m_left--;
        end
        if (acc) begin
            m_pend.push_back(f);
            m_p = f;
        end
    endtask

    task automatic m_check();
        chk("out_valid", out_valid, e_ov);
        chk("out_phase", out_phase, e_ph);
        chk("frame_done", frame_done, e_fd);
        chk("underrun_cnt", underrun_cnt, e_ucnt);
        chk("load", load, m_left == 0);
        chk("in_ready", in_ready, (m_pend.size() == 0) || (m_left == 0 && run));
        chk("din", {din3, din2, din1, din0}, m_p);
        if (e_ov) chk("dout", s_dout, e_samp);
    endtask

    // Model update on each edge with the pre-edge inputs, then compare just after.
    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            m_reset();
        end else begin
            m_step();
            #1;
            if (!Reset) m_check();
        end
    end

    task automatic chk_reset();
        chk("rst_load", load, 1);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_din", {din3, din2, din1, din0}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_phase", out_phase, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_underrun", underrun_cnt, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2 Reset = 1'b1;
        #1 chk_reset();
        @(negedge CLK);
        Reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Offer a frame (called just after a negedge) until accepted, bounded.
    task automatic send(input logic [DW-1:0] a, b, c, d);
        logic accepted;
        accepted = 1'b0;
        in_p0 = a; in_p1 = b; in_p2 = c; in_p3 = d;
        in_valid = 1'b1;
        #1;
        for (int k = 0; k < 20 && !accepted; k++) begin
            if (in_ready) accepted = 1'b1;
            @(negedge CLK);
            if (!accepted) #1;
        end
        in_valid = 1'b0;
        chk("send_accept", accepted, 1);
    endtask

    int sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        #2 chk_reset();
        @(negedge CLK);
        Reset = 1'b0;
        run   = 1'b1;

        // Single frame: 40,30,20,10 then one underrun.
        send(10'd10, 10'd20, 10'd30, 10'd40);
        idle(8);
        chk("single_ucnt", underrun_cnt, 1);

        // Back-to-back: second frame accepted during the first frame's shift.
        do_reset();
        send(10'd10, 10'd20, 10'd30, 10'd40);
        idle(2);
        send(10'd1, 10'd2, 10'd3, 10'd4);
        idle(10);
        chk("b2b_ucnt", underrun_cnt, 1);

        // Backpressure: third frame waits until the HOLD consume edge.
        do_reset();
        send(10'd11, 10'd12, 10'd13, 10'd14);
        send(10'd21, 10'd22, 10'd23, 10'd24);
        send(10'd31, 10'd32, 10'd33, 10'd34);
        idle(14);
        chk("bp_ucnt", underrun_cnt, 1);

        // run dropped mid-frame: frame completes, pending waits, no underrun.
        do_reset();
        send(10'd101, 10'd102, 10'd103, 10'd104);
        send(10'd201, 10'd202, 10'd203, 10'd204);
        idle(1);
        run = 1'b0;
        idle(12);
        chk("run0_load", load, 1);
        chk("run0_ucnt", underrun_cnt, 0);
        run = 1'b1;
        idle(12);

        // Reset in the middle of a shift, then a fresh frame.
        do_reset();
        send(10'd51, 10'd52, 10'd53, 10'd54);
        idle(3);
        do_reset();
        send(10'd5, 10'd6, 10'd7, 10'd8);
        idle(8);

        // Saturation of the 2-bit underrun counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
            idle(8);
            chk("sat_cnt", underrun_cnt, sat_exp[i]);
        end

        // Random traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            run      = ($urandom_range(0, 9) != 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_p0 = DW'($urandom); in_p1 = DW'($urandom);
            in_p2 = DW'($urandom); in_p3 = DW'($urandom);
            @(negedge CLK);
        end
        in_valid = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
